// File: rtl/vram_fetch_pkg.sv
// Shared constants, FSM state type and buffer index helper for the
// video RAM line-prefetch stage.
package vram_fetch_pkg;

    localparam int LINE_WORDS = 32;
    localparam int CW         = $clog2(LINE_WORDS);
    localparam int AW         = 14;
    localparam int RW         = AW - CW;
    localparam int DW         = 16;
    localparam int BW         = CW + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

    // Flat index into the ping-pong buffer: half select on top of column.
    function automatic logic [BW-1:0] buf_index(input logic half, input logic [CW-1:0] col);
        return {half, col};
    endfunction

endpackage

// File: rtl/line_buffer_dp.sv
// Simple dual-port line buffer: synchronous write (fill side) and a
// registered read port (pixel side) whose output register resets to zero.
module line_buffer_dp
    import vram_fetch_pkg::*;
#(
    parameter int DEPTH  = 2 * LINE_WORDS,
    parameter int IW     = $clog2(DEPTH),
    parameter int DWIDTH = DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [IW-1:0]     i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [IW-1:0]     i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] r_rdata;

    // Storage array; contents are deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register: one-cycle latency, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= {DWIDTH{1'b0}};
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vram_line_fetch.sv
// Line-prefetch stage: bursts line N+1 from video RAM into the idle half of a
// ping-pong buffer while the pixel block reads line N from the other half.
module vram_line_fetch
    import vram_fetch_pkg::*;
(
    input  logic          clk_pix,
    input  logic          reset,
    input  logic          line_start,
    input  logic [RW-1:0] next_line,
    input  logic [AW-1:0] vram_addr,
    output logic [DW-1:0] vram_data,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_din,
    output logic          busy,
    output logic          underrun
);

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic          r_active;
    logic [RW-1:0] r_base;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_mem_rd;
    logic          w_mem_rd_nxt;
    logic [AW-1:0] r_mem_addr;
    logic [AW-1:0] w_mem_addr_nxt;
    logic          r_busy;
    logic          r_underrun;
    logic          w_ack_fetch;
    logic          w_last;
    logic          w_abort;
    logic          w_unused_addr;

    assign w_ack_fetch   = (r_state == FETCH) && mem_ack;
    assign w_last        = (r_cnt == CW'(LINE_WORDS - 1));
    // A line_start that coincides with the final ack finds the line complete.
    assign w_abort       = (r_state == FETCH) && line_start && !(w_ack_fetch && w_last);
    assign w_unused_addr = ^vram_addr[AW-1:CW];

    // State register.
    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (line_start) begin
                    w_state_nxt = FETCH;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FETCH: begin
                if (line_start) begin
                    w_state_nxt = FETCH;
                end else if (w_ack_fetch && w_last) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered request outputs and column counter.
    always_comb begin
        w_mem_rd_nxt   = (w_state_nxt == FETCH);
        w_cnt_nxt      = r_cnt;
        w_mem_addr_nxt = r_mem_addr;
        if (line_start) begin
            w_cnt_nxt      = {CW{1'b0}};
            w_mem_addr_nxt = {next_line, {CW{1'b0}}};
        end else if (w_ack_fetch) begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (!w_last) begin
                w_mem_addr_nxt = {r_base, r_cnt + CW'(1)};
            end else begin
                w_mem_addr_nxt = r_mem_addr;
            end
        end else begin
            w_cnt_nxt      = r_cnt;
            w_mem_addr_nxt = r_mem_addr;
        end
    end

    // Datapath and output registers; half swap happens on every line_start.
    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
            r_active   <= 1'b0;
            r_base     <= {RW{1'b0}};
            r_cnt      <= {CW{1'b0}};
            r_mem_rd   <= 1'b0;
            r_mem_addr <= {AW{1'b0}};
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_busy     <= w_mem_rd_nxt;
            if (line_start) begin
                r_active <= ~r_active;
                r_base   <= next_line;
            end
            if (w_abort) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // The fill half is always the inactive one; an ack during an aborting
    // line_start still lands in the half that is about to become active.
    line_buffer_dp #(
        .DEPTH  (2 * LINE_WORDS),
        .IW     (BW),
        .DWIDTH (DW)
    ) u_buf (
        .clk     (clk_pix),
        .rst     (reset),
        .i_we    (w_ack_fetch),
        .i_waddr (buf_index(~r_active, r_cnt)),
        .i_wdata (mem_din),
        .i_raddr (buf_index(r_active, vram_addr[CW-1:0])),
        .o_rdata (vram_data)
    );

    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;
    assign busy     = r_busy;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_vram_line_fetch.sv
// Directed self-checking bench for vram_line_fetch: burst fetch, read-back,
// stalled acks, aborted fetch, asynchronous reset and stray acks in IDLE.
module tb_vram_line_fetch;

    logic        clk_pix;
    logic        reset;
    logic        line_start;
    logic [8:0]  next_line;
    logic [13:0] vram_addr;
    logic [15:0] vram_data;
    logic        mem_rd;
    logic [13:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_din;
    logic        busy;
    logic        underrun;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] exp_d;

    vram_line_fetch dut (
        .clk_pix    (clk_pix),
        .reset      (reset),
        .line_start (line_start),
        .next_line  (next_line),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_din    (mem_din),
        .busy       (busy),
        .underrun   (underrun)
    );

    initial clk_pix = 1'b0;
    always #20 clk_pix = ~clk_pix;

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        line_start = 1'b0;
        next_line  = 9'h000;
        vram_addr  = 14'h0000;
        mem_ack    = 1'b0;
        mem_din    = 16'h0000;
        repeat (3) step();
        chk("rst_mem_rd",   32'(mem_rd),    32'd0);
        chk("rst_mem_addr", 32'(mem_addr),  32'h0);
        chk("rst_vram",     32'(vram_data), 32'h0);
        chk("rst_busy",     32'(busy),      32'd0);
        chk("rst_underrun", 32'(underrun),  32'd0);
        reset = 1'b0;
        step();

        // Test 1: ack tied high, 32 consecutive addresses 0x820..0x83F
        next_line  = 9'h041;
        line_start = 1'b1;
        mem_ack    = 1'b1;
        mem_din    = 16'hFFFF;
        step();
        line_start = 1'b0;
        chk("t1_rd",   32'(mem_rd), 32'd1);
        chk("t1_busy", 32'(busy),   32'd1);
        for (int i = 0; i < 32; i++) begin
            chk("t1_addr", 32'(mem_addr), 32'h0820 + 32'(i));
            mem_din = 16'hA000 + 16'(i);
            step();
        end
        mem_ack = 1'b0;
        chk("t1_rd_end",   32'(mem_rd), 32'd0);
        chk("t1_busy_end", 32'(busy),   32'd0);
        step();
        chk("t1_rd_idle",  32'(mem_rd),   32'd0);
        chk("t1_underrun", 32'(underrun), 32'd0);

        // Test 2: swap, sweep read-back while next line fetches into the other half
        next_line  = 9'h042;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        chk("t2_addr0", 32'(mem_addr), 32'h0840);
        mem_ack = 1'b1;
        for (int i = 0; i < 32; i++) begin
            vram_addr = 14'(i);
            mem_din   = 16'hB000 + 16'(i);
            step();
            chk("t2_read", 32'(vram_data), 32'hA000 + 32'(i));
        end
        mem_ack = 1'b0;
        chk("t2_rd_end", 32'(mem_rd), 32'd0);

        // Test 3: sparse acks with gaps, address held stable while unacked
        next_line  = 9'h043;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            for (int g = 0; g <= (i % 7); g++) begin
                mem_ack = 1'b0;
                step();
            end
            chk("t3_addr_hold", 32'(mem_addr), 32'h0860 + 32'(i));
            chk("t3_rd_hold",   32'(mem_rd),   32'd1);
            vram_addr = 14'h3FE0 | 14'(i);
            mem_ack   = 1'b1;
            mem_din   = 16'hC000 + 16'(i);
            step();
            chk("t3_read_prev", 32'(vram_data), 32'hB000 + 32'(i));
        end
        mem_ack = 1'b0;
        chk("t3_rd_end",   32'(mem_rd),   32'd0);
        chk("t3_underrun", 32'(underrun), 32'd0);

        // Test 4: abort after 10 acks, last ack coincides with line_start
        next_line  = 9'h044;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            vram_addr = 14'(i * 3);
            mem_ack   = 1'b1;
            mem_din   = 16'hD000 + 16'(i);
            step();
            chk("t4_read_t3", 32'(vram_data), 32'hC000 + 32'(i * 3));
        end
        chk("t4_no_underrun", 32'(underrun), 32'd0);
        mem_din    = 16'hD009;
        next_line  = 9'h045;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        mem_ack    = 1'b0;
        chk("t4_underrun", 32'(underrun), 32'd1);
        chk("t4_restart",  32'(mem_addr), 32'h08A0);
        chk("t4_rd",       32'(mem_rd),   32'd1);
        for (int i = 0; i < 32; i++) begin
            vram_addr = 14'(i);
            step();
            exp_d = (i < 10) ? (16'hD000 + 16'(i)) : (16'hB000 + 16'(i));
            chk("t4_partial", 32'(vram_data), 32'(exp_d));
        end
        chk("t4_addr_stable", 32'(mem_addr), 32'h08A0);

        // Test 5: asynchronous reset mid-fetch
        reset = 1'b1;
        #2;
        chk("t5_rd",       32'(mem_rd),    32'd0);
        chk("t5_busy",     32'(busy),      32'd0);
        chk("t5_vram",     32'(vram_data), 32'h0);
        chk("t5_underrun", 32'(underrun),  32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("t5_rd_idle", 32'(mem_rd), 32'd0);
        next_line  = 9'h046;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        chk("t5_addr0", 32'(mem_addr), 32'h08C0);
        chk("t5_rd_on", 32'(mem_rd),   32'd1);
        mem_ack = 1'b1;
        for (int i = 0; i < 32; i++) begin
            mem_din = 16'hE000 + 16'(i);
            step();
        end
        mem_ack = 1'b0;
        chk("t5_rd_end", 32'(mem_rd), 32'd0);

        // Test 6: acks while IDLE must not write
        mem_ack = 1'b1;
        mem_din = 16'hFFFF;
        repeat (5) step();
        chk("t6_rd_idle",   32'(mem_rd), 32'd0);
        chk("t6_busy_idle", 32'(busy),   32'd0);
        mem_ack    = 1'b0;
        next_line  = 9'h047;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            vram_addr = 14'(i);
            step();
            chk("t6_read", 32'(vram_data), 32'hE000 + 32'(i));
        end
        chk("t6_busy_fetch", 32'(busy), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
